// File: rtl/utopia_rx_arbiter.sv
// Round-robin arbiter for the Utopia Rx ports. It grants one cell-valid port
// at a time, holds the grant until the forwarding FSM reports the cell was
// consumed, and forces a release if that report never arrives.
//
// state | meaning
// IDLE  | no grant; search for an eligible port starting at ptr
// GRANT | one port granted; grant held until done or timeout
module utopia_rx_arbiter #(
  parameter int NumRx         = 4,
  parameter int TimeoutCycles = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NumRx-1:0]           req,
  input  logic [NumRx-1:0]           port_en,
  input  logic                       done,
  output logic [NumRx-1:0]           grant,
  output logic                       grant_valid,
  output logic [$clog2(NumRx)-1:0]   grant_idx,
  output logic                       timeout
);

  localparam int          IW      = $clog2(NumRx);
  localparam logic [15:0] LastCnt = 16'(TimeoutCycles - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    ptr, ptr_nxt;
  logic [15:0]      cnt, cnt_nxt;
  logic [NumRx-1:0] grant_nxt;
  logic [IW-1:0]    idx_nxt;
  logic             timeout_nxt;

  logic [NumRx-1:0] eligible;
  logic             pick_found;
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    cand;
  int               pick_sum;

  assign eligible    = req & port_en;
  assign grant_valid = |grant;

  // Rotating priority search: first eligible port at or above ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    pick_sum   = 0;
    for (int i = 0; i < NumRx; i++) begin
      pick_sum = int'(ptr) + i;
      if (pick_sum >= NumRx) pick_sum = pick_sum - NumRx;
      cand = IW'(pick_sum);
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic; done wins over the timeout compare.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    grant_nxt   = grant;
    idx_nxt     = grant_idx;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (pick_found) begin
          state_nxt = GRANT;
          grant_nxt = NumRx'(1) << pick_idx;
          idx_nxt   = pick_idx;
        end
      end
      GRANT: begin
        cnt_nxt = cnt + 16'd1;
        if (done || (cnt == LastCnt)) begin
          state_nxt   = IDLE;
          grant_nxt   = '0;
          idx_nxt     = '0;
          cnt_nxt     = '0;
          ptr_nxt     = (grant_idx == IW'(NumRx - 1)) ? '0 : grant_idx + 1'b1;
          timeout_nxt = !done;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        idx_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, pointer, counter and registered outputs; reset drops any grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      grant     <= '0;
      grant_idx <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      grant     <= grant_nxt;
      grant_idx <= idx_nxt;
      timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_utopia_rx_arbiter.sv
// Directed bench for utopia_rx_arbiter (4 ports, 16-cycle timeout).
// Expected grant indices are queued when requests are driven and popped when
// a grant appears.
module tb_utopia_rx_arbiter;

  localparam int NumRx         = 4;
  localparam int TimeoutCycles = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NumRx-1:0] req;
  logic [NumRx-1:0] port_en;
  logic             done;
  logic [NumRx-1:0] grant;
  logic             grant_valid;
  logic [1:0]       grant_idx;
  logic             timeout;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  utopia_rx_arbiter #(.NumRx(NumRx), .TimeoutCycles(TimeoutCycles)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .port_en    (port_en),
    .done       (done),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait a bounded number of cycles for a grant, then score it.
  task automatic wait_grant(input string tag, input int maxc);
    int n = 0;
    int e;
    while (!grant_valid && n < maxc) begin
      step();
      n++;
    end
    check({tag, "_arrive"}, 32'(grant_valid), 32'd1);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_scoreboard observed=grant expected=no_entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_idx"}, 32'(grant_idx), 32'(e));
      check({tag, "_grant"}, 32'(grant), 32'd1 << e);
    end
  endtask

  // Structural invariants sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("onehot", 32'($onehot0(grant)), 32'd1);
      if (grant_valid) check("idx_match", 32'(grant), 32'd1 << grant_idx);
      else             check("idle_idx", 32'(grant_idx), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int held;
    rst_n = 1'b0; req = '0; port_en = '0; done = 1'b0;
    repeat (3) step();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_gv", 32'(grant_valid), 32'd0);
    check("rst_idx", 32'(grant_idx), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    step();

    // single request, 1-cycle latency, hold after req drops, release
    port_en = 4'hF; req = 4'b0100; exp_q.push_back(2);
    wait_grant("single", 1);
    req = '0;
    step();
    check("single_hold", 32'(grant), 32'h4);
    done = 1'b1; step(); done = 1'b0;
    check("single_rel_gv", 32'(grant_valid), 32'd0);
    check("single_rel_grant", 32'(grant), 32'd0);
    check("single_rel_to", 32'(timeout), 32'd0);

    // pointer moved to 3
    req = 4'hF; exp_q.push_back(3);
    wait_grant("ptr3", 1);
    done = 1'b1; step(); done = 1'b0;

    // round robin with one idle cycle between grants
    for (int k = 0; k < 5; k++) begin
      check("rr_idle", 32'(grant_valid), 32'd0);
      exp_q.push_back(k % 4);
      wait_grant("rr", 1);
      done = 1'b1; step(); done = 1'b0;
    end

    // port_en masking and grant hold against input changes
    req = 4'b0011; port_en = 4'b1110; exp_q.push_back(1);
    wait_grant("mask", 1);
    req = '0; port_en = '0;
    repeat (3) begin
      step();
      check("mask_hold", 32'(grant), 32'h2);
    end
    done = 1'b1; step(); done = 1'b0;
    req = 4'b0011; port_en = 4'b1110; exp_q.push_back(1);
    wait_grant("mask2", 1);
    done = 1'b1; step(); done = 1'b0;

    // timeout with a single requester: back to port 0
    port_en = 4'hF; req = 4'b0001; exp_q.push_back(0);
    wait_grant("to", 1);
    held = 1;
    for (int k = 0; k < 15; k++) begin
      step();
      if (grant_valid && !timeout) held++;
    end
    check("to_held", 32'(held), 32'd16);
    step();
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_drop", 32'(grant_valid), 32'd0);
    exp_q.push_back(0);
    wait_grant("to_back0", 1);
    check("to_once", 32'(timeout), 32'd0);

    // timeout with another requester present: moves to port 1
    req = 4'b0011;
    repeat (16) step();
    check("to2_pulse", 32'(timeout), 32'd1);
    check("to2_drop", 32'(grant_valid), 32'd0);
    exp_q.push_back(1);
    wait_grant("to_other", 1);

    // done coinciding with the last counter value: no timeout
    repeat (15) step();
    done = 1'b1; req = '0; step(); done = 1'b0;
    check("coll_drop", 32'(grant_valid), 32'd0);
    check("coll_to", 32'(timeout), 32'd0);
    step();
    check("coll_to_after", 32'(timeout), 32'd0);

    // done in IDLE is ignored; pointer stays at 2
    done = 1'b1; step(); done = 1'b0;
    check("idle_done_gv", 32'(grant_valid), 32'd0);
    check("idle_done_to", 32'(timeout), 32'd0);
    req = 4'b1100; exp_q.push_back(2);
    wait_grant("ptr_kept", 1);

    // asynchronous reset mid-grant
    #2 rst_n = 1'b0;
    #1;
    check("arst_grant", 32'(grant), 32'd0);
    check("arst_gv", 32'(grant_valid), 32'd0);
    check("arst_idx", 32'(grant_idx), 32'd0);
    check("arst_to", 32'(timeout), 32'd0);
    step();
    rst_n = 1'b1; exp_q.push_back(2);
    wait_grant("post_rst", 1);
    done = 1'b1; step(); done = 1'b0;

    // pointer was 3; reset must restart the search at 0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; exp_q.push_back(2);
    wait_grant("rst_ptr0", 1);
    done = 1'b1; step(); done = 1'b0;
    req = '0;
    step();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
